dma_priority_resolver: RTL

//  Channel request front end of the 8237A-style DMA controller. Qualifies DREQ[3:0] against mask,

---
 rtl/dma_priority_resolver.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_priority_resolver.sv
// ---------------------------------------------------------------------------
// dma_priority_resolver
//
// Channel request front end of an 8237A-style DMA controller. Qualifies the
// raw DREQ pins against the mask register, software requests and the DREQ
// sense polarity. It then arbitrates between the four channels in fixed or
// rotating priority and presents a single one-hot VALID_DREQn to
// timing/control. While timing/control services the winner, this block
// drives that channel's DACK pin.
//
// Handshake: VALID_DREQn is the request ("valid") toward timing/control and
// VALID_DACK is its acceptance ("ready"). Once VALID_DREQn rises, the chosen
// channel is frozen until one of two things happens:
//   - the request is withdrawn before acceptance (cand drops in REQ), or
//   - the service that started with VALID_DACK=1 ends, on eop or when
//     VALID_DACK falls.
// VALID_DREQn never changes channel while it is high.
//
// Configuration macro:
//   DMA_PR_DREQ_SYNC_EN - adds one synchronizer flop in front of the DREQ
//                         sense register. The sense register then acts as the
//                         second synchronizer stage, so DREQ to VALID_DREQn
//                         takes 3 edges instead of 2.
//
// Debug: state_dbg exposes the FSM state (0=IDLE, 1=REQ, 2=SVC) and
// ptr_dbg exposes the rotating-priority pointer.
// ---------------------------------------------------------------------------
module dma_priority_resolver #(
   parameter int NCH   = 4,
   parameter int PTR_W = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [NCH-1:0]   DREQ,
   input  logic [NCH-1:0]   mask,
   input  logic [NCH-1:0]   sw_req,
   input  logic             cmd_disable,
   input  logic             cmd_rot_pri,
   input  logic             cmd_dreq_low,
   input  logic             cmd_dack_high,
   input  logic             hrq,
   input  logic             VALID_DACK,
   input  logic             eop,
   output logic             VALID_DREQ0,
   output logic             VALID_DREQ1,
   output logic             VALID_DREQ2,
   output logic             VALID_DREQ3,
   output logic [NCH-1:0]   DACK,
   output logic [PTR_W-1:0] active_ch,
   output logic [NCH-1:0]   sw_req_clr,
   output logic [1:0]       state_dbg,
   output logic [PTR_W-1:0] ptr_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

   state_t           state_q, state_n;
   logic [PTR_W-1:0] act_q,   act_n;
   logic [PTR_W-1:0] ptr_q,   ptr_n;
   logic [NCH-1:0]   valid_q, valid_n;
   logic [NCH-1:0]   dack_q,  dack_n;
   logic [NCH-1:0]   clr_q,   clr_n;

   // DREQ after sensing: 1 = channel requesting, regardless of pin polarity
   logic [NCH-1:0]   dreq_q;
   logic [NCH-1:0]   cand;
   logic [PTR_W-1:0] win_ch;
   logic             win_found;
   logic [PTR_W-1:0] scan_base;
   logic [PTR_W-1:0] scan_idx;

   function automatic logic [NCH-1:0] ch_onehot(input logic [PTR_W-1:0] ch);
      logic [NCH-1:0] oh;
      oh     = '0;
      oh[ch] = 1'b1;
      return oh;
   endfunction

   // ------------------------------------------------------------------------
   // DREQ input stage
   // ------------------------------------------------------------------------
`ifdef DMA_PR_DREQ_SYNC_EN
   logic [NCH-1:0] dreq_meta_q;

   // First synchronizer flop holds the raw pin level; the sense register is
   // the second stage. On reset it holds the inactive pin level, so no
   // request is seen for the current polarity.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         dreq_meta_q <= {NCH{cmd_dreq_low}};
         dreq_q      <= '0;
      end else begin
         dreq_meta_q <= DREQ;
         dreq_q      <= dreq_meta_q ^ {NCH{cmd_dreq_low}};
      end
   end
`else
   // DREQ is treated as synchronous to CLK: one sense register applies the
   // polarity.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         dreq_q <= '0;
      end else begin
         dreq_q <= DREQ ^ {NCH{cmd_dreq_low}};
      end
   end
`endif

   // Candidate set: hardware requests honour the mask, software requests
   // always count.
   assign cand = (dreq_q & ~mask) | sw_req;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   // Priority scan. The scan starts at channel 0 in fixed mode and at the
   // pointer in rotating mode. It runs from the lowest priority to the
   // highest, so the highest-priority requester is written last and wins.
   always_comb begin
      scan_base = cmd_rot_pri ? ptr_q : '0;
      scan_idx  = '0;
      win_ch    = scan_base;
      win_found = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         scan_idx = scan_base + PTR_W'(k);
         if (cand[scan_idx]) begin
            win_ch    = scan_idx;
            win_found = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Request / service FSM
   // ------------------------------------------------------------------------
   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         act_q   <= '0;
         ptr_q   <= '0;
         valid_q <= '0;
         dack_q  <= '0;
         clr_q   <= '0;
      end else begin
         state_q <= state_n;
         act_q   <= act_n;
         ptr_q   <= ptr_n;
         valid_q <= valid_n;
         dack_q  <= dack_n;
         clr_q   <= clr_n;
      end
   end

   // Next-state and next-output logic. The request and acknowledge outputs
   // are registered, so each decision appears on the pins one edge later.
   always_comb begin
      state_n = state_q;
      act_n   = act_q;
      ptr_n   = ptr_q;
      valid_n = valid_q;
      dack_n  = dack_q;
      clr_n   = '0;

      case (state_q)
         ST_IDLE: begin
            // New arbitration only while enabled and not already holding the bus.
            if (win_found && !cmd_disable && !hrq) begin
               act_n   = win_ch;
               valid_n = ch_onehot(win_ch);
               state_n = ST_REQ;
            end
         end

         ST_REQ: begin
            // The winner stays frozen here. A later higher-priority request
            // does not preempt it, and cmd_disable does not cancel it.
            if (VALID_DACK) begin
               dack_n  = ch_onehot(act_q);
               state_n = ST_SVC;
            end else if (!cand[act_q]) begin
               valid_n = '0;
               state_n = ST_IDLE;
            end
         end

         ST_SVC: begin
            // eop wins over a VALID_DACK fall in the same cycle, so the
            // software request is still cleared in that case.
            if (eop || !VALID_DACK) begin
               valid_n = '0;
               dack_n  = '0;
               if (eop) begin
                  clr_n = ch_onehot(act_q);
               end
               if (cmd_rot_pri) begin
                  ptr_n = act_q + PTR_W'(1);
               end
               state_n = ST_IDLE;
            end
         end

         default: begin
            valid_n = '0;
            dack_n  = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign VALID_DREQ0 = valid_q[0];
   assign VALID_DREQ1 = valid_q[1];
   assign VALID_DREQ2 = valid_q[2];
   assign VALID_DREQ3 = valid_q[3];

   // dack_q holds the active level. The pin polarity follows the command
   // bit directly, so a polarity change applies without waiting for an edge.
   assign DACK       = cmd_dack_high ? dack_q : ~dack_q;
   assign active_ch  = act_q;
   assign sw_req_clr = clr_q;
   assign state_dbg  = state_q;
   assign ptr_dbg    = ptr_q;

endmodule
